// File: rtl/mips_muldiv_hilo_if.sv
// mips_muldiv_hilo_if: issue/result bundle between control path and the HI/LO mul/div unit
interface mips_muldiv_hilo_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mips_muldiv_hilo.sv
// mips_muldiv_hilo: iterative 32-cycle shift-add multiply / restoring divide with HI/LO registers
module mips_muldiv_hilo #(parameter int WIDTH = 32) (
    input logic clk,
    input logic reset,
    mips_muldiv_hilo_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    state_t r_state, w_next;
    logic [CW-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_acc, w_acc, w_prod;
    logic [WIDTH-1:0] r_a, r_b, r_hi, r_lo, w_absa, w_absb, w_q, w_r;
    logic [WIDTH:0] w_sum, w_diff;
    logic r_div, r_neg, r_sa, r_bz, r_done, w_go, w_signed, w_idle;
    assign w_idle = r_state == IDLE;
    assign w_go = w_idle && bus.start && !bus.op[2];
    assign w_signed = !bus.op[0];
    assign w_absa = (w_signed && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    assign w_absb = (w_signed && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    // Multiply keeps {partial product, remaining multiplier}; divide keeps {remainder, dividend/quotient}
    assign w_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
    assign w_diff = r_acc[2*WIDTH-2:WIDTH-1] - {1'b0, r_b};
    assign w_acc = r_div ? (w_diff[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                          : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1})
                         : {w_sum, r_acc[WIDTH-1:1]};
    assign w_prod = r_neg ? -r_acc : r_acc;
    assign w_q = r_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r = r_sa ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    always_comb begin
        w_next = r_state;
        w_next = w_idle ? (w_go ? RUN : IDLE)
               : r_state == RUN ? (r_cnt == CW'(WIDTH-1) ? FIX : RUN)
               : IDLE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else r_state <= w_next;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            r_acc <= '0;
            r_a <= '0;
            r_b <= '0;
            r_hi <= '0;
            r_lo <= '0;
            r_div <= 1'b0;
            r_neg <= 1'b0;
            r_sa <= 1'b0;
            r_bz <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= r_state == FIX;
            if (w_go) begin
                r_acc <= {{WIDTH{1'b0}}, w_absa};
                r_b <= w_absb;
                r_a <= bus.a;
                r_div <= bus.op[1];
                r_neg <= w_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                r_sa <= w_signed && bus.a[WIDTH-1];
                r_bz <= bus.b == '0;
                r_cnt <= '0;
            end
            if (r_state == RUN) begin
                r_acc <= w_acc;
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_idle && bus.start && bus.op == 3'd4) r_hi <= bus.a;
            if (w_idle && bus.start && bus.op == 3'd5) r_lo <= bus.a;
            if (r_state == FIX) begin
                r_hi <= r_div ? (r_bz ? r_a : w_r) : w_prod[2*WIDTH-1:WIDTH];
                r_lo <= r_div ? (r_bz ? {WIDTH{1'b1}} : w_q) : w_prod[WIDTH-1:0];
            end
        end
    end
    assign bus.busy = !w_idle;
    assign bus.done = r_done;
    assign bus.hi = r_hi;
    assign bus.lo = r_lo;
endmodule

// File: tb/tb_mips_muldiv_hilo.sv
// tb_mips_muldiv_hilo: randomized scoreboard bench against an arithmetic HI/LO reference model
module tb_mips_muldiv_hilo;
    typedef struct {
        logic [63:0] r;
        int          cyc;
    } exp_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int cyc = 0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;
    logic [63:0] pend;
    mips_muldiv_hilo_if #(.WIDTH(32)) s();
    mips_muldiv_hilo #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(s.slave));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, t1, t2;
        logic [63:0] p, qq, rr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (op[1] && b == 0) return {a, 32'hFFFF_FFFF};
        case (op)
            3'd0: begin t1 = sa * sb; p = t1; end
            3'd1: p = {32'b0, a} * {32'b0, b};
            3'd2: begin t1 = sa / sb; t2 = sa % sb; qq = t1; rr = t2; p = {rr[31:0], qq[31:0]}; end
            default: p = {a % b, a / b};
        endcase
        return p;
    endfunction
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 300));
            default: return $urandom;
        endcase
    endfunction
    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        s.start = 1'b1;
        s.op = op;
        s.a = a;
        s.b = b;
        @(posedge clk);
        #1;
        s.start = 1'b0;
        s.a = $urandom;
        s.b = $urandom;
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        drive(op, a, b);
        if (op < 3'd4) begin
            pend = ref_op(op, a, b);
            q.push_back('{r: pend, cyc: cyc + 33});
            chk("busy_after_start", {31'b0, s.busy}, 32'd1);
        end else begin
            if (op == 3'd4) model_hi = a;
            if (op == 3'd5) model_lo = a;
            chk("mt_hi", s.hi, model_hi);
            chk("mt_lo", s.lo, model_lo);
            chk("mt_busy", {31'b0, s.busy}, 32'd0);
            @(negedge clk);
            chk("mt_done", {31'b0, s.done}, 32'd0);
        end
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 40 && s.busy; i++) @(negedge clk);
        chk("busy_timeout", {31'b0, s.busy}, 32'd0);
        @(posedge clk);
        #1;
        model_hi = pend[63:32];
        model_lo = pend[31:0];
    endtask
    task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        issue(op, a, b);
        if (op < 3'd4) wait_idle();
    endtask
    initial begin
        logic prev_done;
        logic [2:0] rop;
        s.start = 1'b0;
        s.op = 3'd0;
        s.a = '0;
        s.b = '0;
        #3;
        chk("rst_hi", s.hi, 32'h0);
        chk("rst_lo", s.lo, 32'h0);
        chk("rst_busy", {31'b0, s.busy}, 32'd0);
        chk("rst_done", {31'b0, s.done}, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        fork
            begin
                prev_done = 1'b0;
                forever begin
                    @(negedge clk);
                    if (!reset) begin
                        if (prev_done) chk("done_pulse", {31'b0, s.done}, 32'd0);
                        if (s.done) begin
                            if (q.size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL unexpected_done: got done=1 expected none pending");
                            end else begin
                                exp_t e;
                                e = q.pop_front();
                                chk("res_hi", s.hi, e.r[63:32]);
                                chk("res_lo", s.lo, e.r[31:0]);
                                chk("latency", cyc, e.cyc);
                                chk("done_busy", {31'b0, s.busy}, 32'd0);
                            end
                        end
                        prev_done = s.done;
                    end else prev_done = 1'b0;
                end
            end
        join_none
        run(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run(3'd0, -32'sd3, 32'd7);
        run(3'd0, 32'h8000_0000, 32'h8000_0000);
        run(3'd2, -32'sd7, 32'd2);
        run(3'd3, 32'd100, 32'd7);
        run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run(3'd3, 32'h1234, 32'd0);
        run(3'd2, -32'sd5, 32'd0);
        run(3'd4, 32'hDEAD_BEEF, 32'd0);
        run(3'd5, 32'h0BAD_F00D, 32'd0);
        issue(3'd0, -32'sd3, 32'd7);
        repeat (5) @(negedge clk);
        drive(3'd5, 32'h5555_5555, 32'd0);
        drive(3'd4, 32'h6666_6666, 32'd0);
        drive(3'd1, 32'd9, 32'd9);
        wait_idle();
        issue(3'd1, 32'd5, 32'd5);
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        q.delete();
        chk("abort_hi", s.hi, 32'h0);
        chk("abort_lo", s.lo, 32'h0);
        chk("abort_busy", {31'b0, s.busy}, 32'd0);
        chk("abort_done", {31'b0, s.done}, 32'd0);
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        run(3'd1, 32'd6, 32'd7);
        chk("mul67_lo", s.lo, 32'd42);
        for (int i = 0; i < 30; i++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop > 3'd5) begin
                drive(rop, $urandom, $urandom);
                chk("nop_hi", s.hi, model_hi);
                chk("nop_lo", s.lo, model_lo);
                chk("nop_busy", {31'b0, s.busy}, 32'd0);
            end else run(rop, pick(), pick());
        end
        repeat (3) @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
